// File: rtl/seg_pkg.sv
// Shared seven-segment constants: glyph patterns, anode selects and the sampled bus layout.
// Used by the display scanner, the encoder and the capture monitor.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NIBBLE_W   = 4;

    // Active-low segment patterns, {g,f,e,d,c,b,a}.
    localparam logic [SEG_W-1:0] GLYPH_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0010000;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'b0000011;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'b1000110;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'b0100001;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'b0000110;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'b0001110;
    localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b1111111;

    // Anode selects, one-hot-low.
    localparam logic [NUM_DIGITS-1:0] AN_DIG0 = 4'b1110;
    localparam logic [NUM_DIGITS-1:0] AN_DIG1 = 4'b1101;
    localparam logic [NUM_DIGITS-1:0] AN_DIG2 = 4'b1011;
    localparam logic [NUM_DIGITS-1:0] AN_DIG3 = 4'b0111;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE = 4'b1111;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] an;
        logic                  dp;
        logic [SEG_W-1:0]      seg;
    } bus_t;

    localparam bus_t BUS_IDLE = '{an: AN_IDLE, dp: 1'b1, seg: GLYPH_BLANK};

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } slot_t;

    // Idle or multi-low anode patterns yield valid = 0.
    function automatic slot_t an_decode(input logic [NUM_DIGITS-1:0] an);
        slot_t s;
        s = '{valid: 1'b0, idx: 2'd0};
        case (an)
            AN_DIG0: s = '{valid: 1'b1, idx: 2'd0};
            AN_DIG1: s = '{valid: 1'b1, idx: 2'd1};
            AN_DIG2: s = '{valid: 1'b1, idx: 2'd2};
            AN_DIG3: s = '{valid: 1'b1, idx: 2'd3};
            default: s = '{valid: 1'b0, idx: 2'd0};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Inverse of the seven-segment encoder: active-low glyph to hex nibble.
// Any pattern outside the sixteen hex glyphs reports err with nibble 0.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0]    seg,
    output logic [NIBBLE_W-1:0] nibble,
    output logic                err
);

    always_comb begin
        nibble = 4'h0;
        err    = 1'b0;
        case (seg)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_display_capture.sv
// Receive side of the multiplexed 4-digit display bus: synchronize, wait for each scan slot
// to settle, decode the glyph and assemble the four digits into a frame.
module seg_display_capture
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [SEG_W-1:0]               seg_in,
    input  logic [NUM_DIGITS-1:0]          an_in,
    input  logic                           dp_in,
    output logic [NUM_DIGITS*NIBBLE_W-1:0] digits,
    output logic [NUM_DIGITS-1:0]          dp_out,
    output logic [NUM_DIGITS-1:0]          digit_err,
    output logic                           frame_valid
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(STABLE_CYCLES - 1);

    bus_t bus_in;
    bus_t sync1_q, sync2_q, prev_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_DIGITS*NIBBLE_W-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]          dp_q, dp_d;
    logic [NUM_DIGITS-1:0]          err_q, err_d;
    logic [NUM_DIGITS-1:0]          mask_q, mask_d;
    logic                           frame_q, frame_d;

    logic                stable;
    logic                capture;
    slot_t               slot;
    logic [NIBBLE_W-1:0] dec_nibble;
    logic                dec_err;

    assign bus_in = '{an: an_in, dp: dp_in, seg: seg_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= BUS_IDLE;
            sync2_q <= BUS_IDLE;
            prev_q  <= BUS_IDLE;
        end else begin
            sync1_q <= bus_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    seg7_decode u_decode (
        .seg    (sync2_q.seg),
        .nibble (dec_nibble),
        .err    (dec_err)
    );

    // Capture fires only on the single count step into saturation, so a long slot
    // is captured exactly once.
    always_comb begin
        stable  = (sync2_q == prev_q);
        slot    = an_decode(sync2_q.an);
        capture = stable && (cnt_q == CNT_TRIG) && slot.valid;

        cnt_d = cnt_q;
        if (!stable) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        digits_d = digits_q;
        dp_d     = dp_q;
        err_d    = err_q;
        mask_d   = mask_q;
        frame_d  = (mask_q == '1);

        if (capture) begin
            digits_d[{slot.idx, 2'b00} +: NIBBLE_W] = dec_nibble;
            dp_d[slot.idx]                          = ~sync2_q.dp;
            err_d[slot.idx]                         = dec_err;
        end

        // A completed mask clears a cycle after it fills; slots are too long for a
        // capture to land on that same cycle.
        if (frame_d) begin
            mask_d = '0;
        end else if (capture) begin
            mask_d[slot.idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            digits_q <= '0;
            dp_q     <= '0;
            err_q    <= '0;
            mask_q   <= '0;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            err_q    <= err_d;
            mask_q   <= mask_d;
            frame_q  <= frame_d;
        end
    end

    assign digits      = digits_q;
    assign dp_out      = dp_q;
    assign digit_err   = err_q;
    assign frame_valid = frame_q;

endmodule

// File: tb/tb_seg_display_capture.sv
// Bench for seg_display_capture: a pin-history model checked every cycle, plus directed
// scans with hand-computed expectations.
module tb_seg_display_capture;

    localparam int unsigned S  = 16;
    localparam int unsigned HD = S + 3;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  seg_in = 7'h7f;
    logic [3:0]  an_in = 4'hf;
    logic        dp_in = 1'b1;
    logic [15:0] digits;
    logic [3:0]  dp_out;
    logic [3:0]  digit_err;
    logic        frame_valid;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int frame_cnt = 0;
    int f0;

    seg_display_capture #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .dp_in       (dp_in),
        .digits      (digits),
        .dp_out      (dp_out),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: hist[i] is the pin vector {an,dp,seg} presented i+1 edges ago (idle before reset).
    // A slot is captured when its value has been presented for exactly S+1 consecutive edges,
    // counted from two edges back to allow for the synchronizer.
    logic [11:0] hist [HD];
    logic [15:0] m_digits;
    logic [3:0]  m_dp, m_err, m_seen;
    logic        m_frame;
    logic        m_cap, m_bad;
    logic [3:0]  m_nib;
    logic [1:0]  m_idx;

    always_comb begin
        m_cap = ($countones(~hist[1][11:8]) == 1) && (hist[S+2] != hist[S+1]);
        for (int i = 2; i <= S + 1; i++) begin
            if (hist[i] != hist[1]) m_cap = 1'b0;
        end
        m_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!hist[1][8+i]) m_idx = 2'(i);
        end
        m_nib = 4'h0;
        m_bad = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (GLYPH[i] == hist[1][6:0]) begin
                m_nib = 4'(i);
                m_bad = 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HD; i++) hist[i] <= 12'hfff;
            m_digits <= '0;
            m_dp     <= '0;
            m_err    <= '0;
            m_seen   <= '0;
            m_frame  <= 1'b0;
        end else begin
            hist[0] <= {an_in, dp_in, seg_in};
            for (int i = 1; i < HD; i++) hist[i] <= hist[i-1];
            if (m_cap) begin
                m_digits[{m_idx, 2'b00} +: 4] <= m_nib;
                m_dp[m_idx]                   <= ~hist[1][7];
                m_err[m_idx]                  <= m_bad;
            end
            m_frame <= (m_seen == 4'hf);
            if (m_seen == 4'hf) m_seen <= '0;
            else if (m_cap) m_seen[m_idx] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        check("digits", 32'(digits), 32'(m_digits));
        check("dp_out", 32'(dp_out), 32'(m_dp));
        check("digit_err", 32'(digit_err), 32'(m_err));
        check("frame_valid", 32'(frame_valid), 32'(m_frame));
        if (frame_valid) frame_cnt <= frame_cnt + 1;
    end

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int n);
        an_in  = an;
        seg_in = seg;
        dp_in  = dp;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic slot(input int k, input logic [6:0] seg, input logic dp);
        drive(~(4'b0001 << k), seg, dp, 64);
    endtask

    task automatic slot_glitch(input int k, input logic [6:0] seg, input logic dp);
        drive(~(4'b0001 << k), seg, dp, 25);
        drive(~(4'b0001 << k), GLYPH[8], dp, 10);
        drive(~(4'b0001 << k), seg, dp, 29);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset digits", 32'(digits), 32'h0);
        check("reset dp_out", 32'(dp_out), 32'h0);
        check("reset digit_err", 32'(digit_err), 32'h0);
        check("reset frame_valid", 32'(frame_valid), 32'h0);

        // Two full scans of 1,2,3,4 from digit 3 down; digit 2 has its point lit.
        f0 = frame_cnt;
        repeat (2) begin
            slot(3, GLYPH[1], 1'b1);
            slot(2, GLYPH[2], 1'b0);
            slot(1, GLYPH[3], 1'b1);
            slot(0, GLYPH[4], 1'b1);
        end
        check("scan digits", 32'(digits), 32'h1234);
        check("scan digit_err", 32'(digit_err), 32'h0);
        check("scan dp_out", 32'(dp_out), 32'h4);
        check("scan frames", 32'(frame_cnt - f0), 32'd2);

        // 10-cycle glitches inside every slot.
        f0 = frame_cnt;
        slot_glitch(3, GLYPH[1], 1'b1);
        slot_glitch(2, GLYPH[2], 1'b0);
        slot_glitch(1, GLYPH[3], 1'b1);
        slot_glitch(0, GLYPH[4], 1'b1);
        check("glitch digits", 32'(digits), 32'h1234);
        check("glitch frames", 32'(frame_cnt - f0), 32'd1);

        // Blank pattern on digit 2, then a legal 7.
        slot(3, GLYPH[1], 1'b1);
        slot(2, 7'b1111111, 1'b1);
        slot(1, GLYPH[3], 1'b1);
        slot(0, GLYPH[4], 1'b1);
        check("bad nibble", 32'(digits[11:8]), 32'h0);
        check("bad digit_err", 32'(digit_err), 32'h4);
        slot(3, GLYPH[1], 1'b1);
        slot(2, GLYPH[7], 1'b1);
        slot(1, GLYPH[3], 1'b1);
        slot(0, GLYPH[4], 1'b1);
        check("fixed digits", 32'(digits), 32'h1734);
        check("fixed digit_err", 32'(digit_err), 32'h0);

        // Hold F on digit 0: not captured after 18 edges, captured on the 19th (t+18).
        drive(4'b1110, GLYPH[15], 1'b0, 18);
        check("hold before t+18", 32'(digits[3:0]), 32'h4);
        drive(4'b1110, GLYPH[15], 1'b0, 1);
        check("hold at t+18", 32'(digits[3:0]), 32'hf);
        check("hold dp_out0", 32'(dp_out[0]), 32'h1);
        drive(4'b1110, GLYPH[15], 1'b0, 40);

        // Digit 0 twice, then 1..3: one frame, only after digit 3.
        f0 = frame_cnt;
        slot(0, GLYPH[5], 1'b1);
        slot(0, GLYPH[9], 1'b1);
        slot(1, GLYPH[8], 1'b1);
        slot(2, GLYPH[10], 1'b1);
        check("repeat no early frame", 32'(frame_cnt - f0), 32'd0);
        slot(3, GLYPH[12], 1'b1);
        check("repeat frames", 32'(frame_cnt - f0), 32'd1);
        check("repeat digits", 32'(digits), 32'hca89);

        // Reset mid-slot, release with the slot still driven.
        drive(4'b1101, GLYPH[11], 1'b0, 8);
        rst_n = 1'b0;
        #1;
        check("midreset digits", 32'(digits), 32'h0);
        check("midreset dp_out", 32'(dp_out), 32'h0);
        check("midreset digit_err", 32'(digit_err), 32'h0);
        check("midreset frame_valid", 32'(frame_valid), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(4'b1101, GLYPH[11], 1'b0, 18);
        check("post-reset early", 32'(digits), 32'h0);
        drive(4'b1101, GLYPH[11], 1'b0, 1);
        check("post-reset capture", 32'(digits), 32'h00b0);
        check("post-reset dp_out", 32'(dp_out), 32'h2);

        // Idle bus: nothing captured, no frame.
        f0 = frame_cnt;
        drive(4'b1111, 7'h7f, 1'b1, 100);
        check("idle frames", 32'(frame_cnt - f0), 32'd0);
        check("idle digits", 32'(digits), 32'h00b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seg_display_capture.md
# seg_display_capture

Receive side of the multiplexed 4-digit seven-segment display bus. Samples the active-low segment, anode and decimal-point lines driven by a display scanner, waits for each scan slot to settle, decodes the glyph back to a hex nibble and assembles all four digits into a frame. Used as a loopback monitor and self-check on the board and in benches, and for reading a display driven by external hardware.

## Interface
- STABLE_CYCLES, 16: consecutive clk cycles the synchronized an/seg/dp vector must hold unchanged before a slot is captured; legal range 2..65535.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- seg_in  in  7  segment lines, active low, bit0=a … bit6=g.
- an_in  in  4  anode lines, active low, one-hot-low selects a digit.
- dp_in  in  1  decimal point, active low.
- digits  out  16  captured hex values; digit k at [4k+3:4k].
- dp_out  out  4  captured decimal points, active high, bit k = digit k.
- digit_err  out  4  bit k set when digit k's last glyph was not a legal hex glyph.
- frame_valid  out  1  one-cycle pulse when all four digits have been captured since the previous pulse.

## Operation
- All 12 input bits pass through a 2-flop synchronizer; the synchronizer resets to all-ones (idle, everything dark).
- A prev register holds the last synchronized vector. A change clears the stability counter to 0; otherwise the counter increments, saturating at STABLE_CYCLES.
- Capture: on the edge where the counter reaches STABLE_CYCLES-1 → STABLE_CYCLES, and only then, if an is one-hot-low. One capture per stable period, however long it lasts.
- Digit index: an 1110→0, 1101→1, 1011→2, 0111→3. an = 1111 or more than one bit low: no capture, no error, counter still runs.
- Decode (seg active low, {g..a}): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. This is exactly the inverse of seven_segment.
- Unknown pattern: nibble stored as 0, digit_err[k] set. A legal glyph clears digit_err[k]. dp_out[k] = ~dp_in.
- Frame: a 4-bit seen mask sets bit k on each capture. A capture for a digit already in the mask overwrites its value and leaves the mask unchanged. When the mask becomes 1111, frame_valid pulses on the next cycle and the mask clears in the same cycle.

## Timing
- Reset values: digits=0, dp_out=0, digit_err=0, frame_valid=0, mask=0, counter=0, prev=all-ones, synchronizer=all-ones.
- Latency: with the pins settled before edge t, digits/dp_out/digit_err update at edge t+2+STABLE_CYCLES (2 synchronizer edges, then the stability count). frame_valid rises one edge after the fourth capture.
- A glitch shorter than STABLE_CYCLES cycles never causes a capture; it only restarts the count.
- Reset mid-slot: everything returns to reset values immediately. After release, the current slot is captured only after a full stable period.
- A capture and a mask clear cannot coincide; the mask clears one cycle after completion, and slots last at least STABLE_CYCLES ≥ 2 cycles.

## Structure
- Package seg_pkg: NUM_DIGITS=4, the 16 glyph constants, and the an one-hot-low patterns. These are shared with seven_segment and the scanner.
- Sub-module seg7_decode: combinational 7-bit pattern → {nibble, err}.
- Top: synchronizer, stability counter, capture registers and frame mask.

## Test plan
- Scan 1,2,3,4 on an 0111/1011/1101/1110 with 64-cycle slots, STABLE_CYCLES=16 → digits=16'h1234, digit_err=0, exactly one frame_valid pulse per full scan.
- Hold an=1110, seg=0001110 (F), dp low → digit 0 updates exactly 18 edges after the pins settle (2+16); digits[3:0]=F, dp_out[0]=1.
- Insert 10-cycle segment glitches within slots → no spurious capture, values unchanged, frame timing unaffected.
- seg=1111111 on digit 2 → digits[11:8]=0, digit_err[2]=1. Next scan with a legal 7 → digit_err[2]=0, digits[11:8]=7.
- Scan digits 0,0,1,2,3 (digit 0 repeated) → mask completes only after digit 3, frame_valid pulses once, and digit 0 holds the second value.
- Assert rst_n low mid-slot → all outputs 0 immediately. After release, the first capture occurs only after STABLE_CYCLES stable cycles; an=1111 idle gives no capture and no frame_valid.
